// File: rtl/tdm_demux_1x4.sv
// tdm_demux_1x4: splits a time-multiplexed sample stream into NUM_CH per-channel
// holding registers, aligned by frame_sync. Slot 0 is marked by frame_sync;
// samples seen before the first sync are dropped. A sync that arrives while a
// frame is still open restarts the frame at slot 0 and is flagged as an error.
module tdm_demux_1x4 #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NUM_CH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DATA_W-1:0]          din,
   input  logic                       din_valid,
   input  logic                       frame_sync,
   output logic [NUM_CH*DATA_W-1:0]   dout,
   output logic [NUM_CH-1:0]          dout_valid,
   output logic                       frame_done,
   output logic                       frame_err,
   output logic [7:0]                 err_count
);

   localparam int unsigned SLOT_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned OUT_W     = NUM_CH * DATA_W;
   localparam int unsigned ERR_W     = 8;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);
   localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

   // Reject channel counts the slot logic is not sized for.
   if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
      $error("tdm_demux_1x4: NUM_CH must be in 2..16");
   end

   typedef enum logic [0:0] {
      HUNT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [SLOT_W-1:0]   slot_q;
   logic [SLOT_W-1:0]   slot_d;

   logic                wr_en;
   logic [SLOT_W-1:0]   wr_ch;
   logic                err_d;

   logic [OUT_W-1:0]    dout_d;
   logic [NUM_CH-1:0]   dout_valid_d;
   logic                frame_done_d;
   logic [ERR_W-1:0]    err_count_d;

   // State and slot registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HUNT;
         slot_q  <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
      end
   end

   // Next-state logic: decide which channel (if any) the current sample writes.
   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      wr_en   = 1'b0;
      wr_ch   = '0;
      err_d   = 1'b0;
      if (din_valid) begin
         case (state_q)
            HUNT: begin
               // Without a sync there is no frame to place the sample in.
               if (frame_sync) begin
                  wr_en   = 1'b1;
                  wr_ch   = '0;
                  slot_d  = SLOT_W'(1);
                  state_d = RUN;
               end
            end
            RUN: begin
               if (frame_sync) begin
                  // Premature sync: abandon the open frame and restart at slot 0.
                  wr_en  = 1'b1;
                  wr_ch  = '0;
                  slot_d = SLOT_W'(1);
                  err_d  = 1'b1;
               end else begin
                  wr_en = 1'b1;
                  wr_ch = slot_q;
                  if (slot_q == LAST_SLOT) begin
                     slot_d  = '0;
                     state_d = HUNT;
                  end else begin
                     slot_d = slot_q + SLOT_W'(1);
                  end
               end
            end
            default: begin
               state_d = HUNT;
               slot_d  = '0;
            end
         endcase
      end
   end

   // Output next values: channel write, one-hot strobe, frame/err pulses, error counter.
   always_comb begin
      dout_d       = dout;
      dout_valid_d = '0;
      frame_done_d = 1'b0;
      err_count_d  = err_count;
      if (wr_en) begin
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (wr_ch == SLOT_W'(k)) begin
               dout_d[k*DATA_W +: DATA_W] = din;
               dout_valid_d[k]            = 1'b1;
            end
         end
         frame_done_d = (wr_ch == LAST_SLOT);
      end
      if (err_d && (err_count != ERR_MAX)) begin
         err_count_d = err_count + ERR_W'(1);
      end
   end

   // Registered outputs; nothing reaches a port combinationally from the inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout       <= '0;
         dout_valid <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         err_count  <= '0;
      end else begin
         dout       <= dout_d;
         dout_valid <= dout_valid_d;
         frame_done <= frame_done_d;
         frame_err  <= err_d;
         err_count  <= err_count_d;
      end
   end

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Bench for tdm_demux_1x4: directed vector table, saturation sequence and a
// randomized run checked against a frame-position reference model.
module tb_tdm_demux_1x4;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned NUM_CH = 4;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic [DATA_W-1:0]         din;
   logic                      din_valid;
   logic                      frame_sync;
   logic [NUM_CH*DATA_W-1:0]  dout;
   logic [NUM_CH-1:0]         dout_valid;
   logic                      frame_done;
   logic                      frame_err;
   logic [7:0]                err_count;

   tdm_demux_1x4 #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .frame_sync (frame_sync),
      .dout       (dout),
      .dout_valid (dout_valid),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        rst;
      logic        v;
      logic        s;
      logic [7:0]  d;
      logic [31:0] e_dout;
      logic [3:0]  e_dv;
      logic        e_fd;
      logic        e_fe;
      logic [7:0]  e_ec;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
   task automatic drive_cycle(input logic r, input logic v, input logic s, input logic [7:0] d);
      @(negedge clk);
      rst_n      = r;
      din_valid  = v;
      frame_sync = s;
      din        = d;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic v, input logic s, input logic [7:0] d,
                      input logic [31:0] e_dout, input logic [3:0] e_dv,
                      input logic e_fd, input logic e_fe, input logic [7:0] e_ec);
      vec_t t;
      t.rst = r; t.v = v; t.s = s; t.d = d;
      t.e_dout = e_dout; t.e_dv = e_dv; t.e_fd = e_fd; t.e_fe = e_fe; t.e_ec = e_ec;
      vecs.push_back(t);
   endtask

   // Reference model state: position inside the current frame, -1 when none is open.
   int          m_pos;
   logic [7:0]  m_ch [NUM_CH];
   int          m_errs;

   task automatic model_reset();
      m_pos  = -1;
      m_errs = 0;
      for (int k = 0; k < NUM_CH; k++) m_ch[k] = 8'h00;
   endtask

   task automatic run_random(input int cycles);
      logic        r, v, s;
      logic [7:0]  d;
      logic [3:0]  e_dv;
      logic        e_fd, e_fe;
      logic [31:0] e_dout;
      for (int c = 0; c < cycles; c++) begin
         r = ($urandom_range(0, 199) != 0);
         v = ($urandom_range(0, 9) < 7);
         s = ($urandom_range(0, 3) == 0);
         d = 8'($urandom);
         e_dv = 4'h0; e_fd = 1'b0; e_fe = 1'b0;
         if (!r) begin
            model_reset();
         end else if (v) begin
            if (s) begin
               if (m_pos >= 0) begin
                  e_fe = 1'b1;
                  if (m_errs < 255) m_errs++;
               end
               m_ch[0] = d;
               e_dv    = 4'b0001;
               m_pos   = 1;
            end else if (m_pos >= 0) begin
               m_ch[m_pos] = d;
               e_dv = 4'(1 << m_pos);
               if (m_pos == NUM_CH - 1) begin
                  e_fd  = 1'b1;
                  m_pos = -1;
               end else begin
                  m_pos++;
               end
            end
         end
         for (int k = 0; k < NUM_CH; k++) e_dout[k*8 +: 8] = m_ch[k];
         drive_cycle(r, v, s, d);
         check($sformatf("rnd%0d dout", c), 64'(dout), 64'(e_dout));
         check($sformatf("rnd%0d dout_valid", c), 64'(dout_valid), 64'(e_dv));
         check($sformatf("rnd%0d frame_done", c), 64'(frame_done), 64'(e_fd));
         check($sformatf("rnd%0d frame_err", c), 64'(frame_err), 64'(e_fe));
         check($sformatf("rnd%0d err_count", c), 64'(err_count), 64'(m_errs));
      end
   endtask

   initial begin
      rst_n = 1'b0; din_valid = 1'b0; frame_sync = 1'b0; din = '0;

      // Reset state
      add(0,0,0,8'h00, 32'h00000000, 4'b0000, 0,0,8'd0);
      // Clean frame
      add(1,1,1,8'h11, 32'h00000011, 4'b0001, 0,0,8'd0);
      add(1,1,0,8'h22, 32'h00002211, 4'b0010, 0,0,8'd0);
      add(1,1,0,8'h33, 32'h00332211, 4'b0100, 0,0,8'd0);
      add(1,1,0,8'h44, 32'h44332211, 4'b1000, 1,0,8'd0);
      // Hunt: unsynced samples dropped, then a new frame
      add(1,1,0,8'hAA, 32'h44332211, 4'b0000, 0,0,8'd0);
      add(1,1,0,8'hBB, 32'h44332211, 4'b0000, 0,0,8'd0);
      add(1,1,1,8'h01, 32'h44332201, 4'b0001, 0,0,8'd0);
      add(1,1,0,8'h02, 32'h44330201, 4'b0010, 0,0,8'd0);
      add(1,1,0,8'h03, 32'h44030201, 4'b0100, 0,0,8'd0);
      add(1,1,0,8'h04, 32'h04030201, 4'b1000, 1,0,8'd0);
      // Premature sync, starting right after frame_done
      add(1,1,1,8'h10, 32'h04030210, 4'b0001, 0,0,8'd0);
      add(1,1,0,8'h20, 32'h04032010, 4'b0010, 0,0,8'd0);
      add(1,1,1,8'h30, 32'h04032030, 4'b0001, 0,1,8'd1);
      add(1,1,0,8'h40, 32'h04034030, 4'b0010, 0,0,8'd1);
      add(1,1,0,8'h50, 32'h04504030, 4'b0100, 0,0,8'd1);
      add(1,1,0,8'h60, 32'h60504030, 4'b1000, 1,0,8'd1);
      // Gaps with frame_sync toggling while din_valid is low
      add(0,0,0,8'h00, 32'h00000000, 4'b0000, 0,0,8'd0);
      add(1,1,1,8'h11, 32'h00000011, 4'b0001, 0,0,8'd0);
      add(1,0,1,8'h5A, 32'h00000011, 4'b0000, 0,0,8'd0);
      add(1,0,0,8'hA5, 32'h00000011, 4'b0000, 0,0,8'd0);
      add(1,0,1,8'h5A, 32'h00000011, 4'b0000, 0,0,8'd0);
      add(1,1,0,8'h22, 32'h00002211, 4'b0010, 0,0,8'd0);
      add(1,0,1,8'h5A, 32'h00002211, 4'b0000, 0,0,8'd0);
      add(1,0,0,8'hA5, 32'h00002211, 4'b0000, 0,0,8'd0);
      add(1,0,1,8'h5A, 32'h00002211, 4'b0000, 0,0,8'd0);
      add(1,1,0,8'h33, 32'h00332211, 4'b0100, 0,0,8'd0);
      add(1,0,1,8'h5A, 32'h00332211, 4'b0000, 0,0,8'd0);
      add(1,0,0,8'hA5, 32'h00332211, 4'b0000, 0,0,8'd0);
      add(1,0,1,8'h5A, 32'h00332211, 4'b0000, 0,0,8'd0);
      add(1,1,0,8'h44, 32'h44332211, 4'b1000, 1,0,8'd0);
      // Reset mid-frame, then unsynced samples must not write
      add(1,1,1,8'h11, 32'h44332211, 4'b0001, 0,0,8'd0);
      add(1,1,0,8'h22, 32'h44332211, 4'b0010, 0,0,8'd0);
      add(0,1,0,8'h99, 32'h00000000, 4'b0000, 0,0,8'd0);
      add(1,1,0,8'h33, 32'h00000000, 4'b0000, 0,0,8'd0);
      add(1,1,0,8'h44, 32'h00000000, 4'b0000, 0,0,8'd0);

      foreach (vecs[i]) begin
         drive_cycle(vecs[i].rst, vecs[i].v, vecs[i].s, vecs[i].d);
         check($sformatf("vec%0d dout", i), 64'(dout), 64'(vecs[i].e_dout));
         check($sformatf("vec%0d dout_valid", i), 64'(dout_valid), 64'(vecs[i].e_dv));
         check($sformatf("vec%0d frame_done", i), 64'(frame_done), 64'(vecs[i].e_fd));
         check($sformatf("vec%0d frame_err", i), 64'(frame_err), 64'(vecs[i].e_fe));
         check($sformatf("vec%0d err_count", i), 64'(err_count), 64'(vecs[i].e_ec));
      end

      // Saturation: one opening sync then 300 premature syncs back to back
      drive_cycle(0, 0, 0, 8'h00);
      drive_cycle(1, 1, 1, 8'h00);
      check("sat open frame_err", 64'(frame_err), 64'(0));
      for (int i = 0; i < 300; i++) begin
         drive_cycle(1, 1, 1, 8'(i));
         check($sformatf("sat%0d frame_err", i), 64'(frame_err), 64'(1));
         check($sformatf("sat%0d err_count", i), 64'(err_count), 64'((i + 1 > 255) ? 255 : i + 1));
         check($sformatf("sat%0d dout_valid", i), 64'(dout_valid), 64'(4'b0001));
      end

      // Randomized run against the reference model
      drive_cycle(0, 0, 0, 8'h00);
      model_reset();
      run_random(3000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tdm_demux_1x4.md
TDM_DEMUX_1X4 -- requirements
Module: tdm_demux_1x4

Interface
REQ-001 Parameter DATA_W, default 8, sample width in bits.
REQ-002 Parameter NUM_CH, default 4, channels per frame; legal values 2..16.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port din  input  DATA_W  shared time-multiplexed sample line.
REQ-006 Port din_valid  input  1  din carries a sample this cycle.
REQ-007 Port frame_sync  input  1  qualifies the current sample as slot 0; ignored when din_valid=0.
REQ-008 Port dout  output  NUM_CH*DATA_W  per-channel holding registers; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 Port dout_valid  output  NUM_CH  per-channel one-cycle update strobes.
REQ-010 Port frame_done  output  1  one-cycle pulse when slot NUM_CH-1 is written.
REQ-011 Port frame_err  output  1  one-cycle pulse on a premature frame_sync.
REQ-012 Port err_count  output  8  saturating count of frame_err events.

Function
REQ-013 Two-state FSM: HUNT (no frame in progress) and RUN (frame in progress); slot counter width ceil(log2(NUM_CH)).
REQ-014 "Accept" = rising edge with din_valid=1 that writes a channel per REQ-015..REQ-018.
REQ-015 HUNT with din_valid=1, frame_sync=0: sample dropped; no output changes; state stays HUNT.
REQ-016 HUNT with din_valid=1, frame_sync=1: write channel 0; slot<=1; state<=RUN.
REQ-017 RUN with din_valid=1, frame_sync=0: write channel slot; if slot=NUM_CH-1 then slot<=0 and state<=HUNT, else slot<=slot+1.
REQ-018 RUN with din_valid=1, frame_sync=1 (premature sync, any slot >=1): write channel 0; slot<=1; state stays RUN; frame_err pulses; err_count increments.
REQ-019 din_valid=0: FSM, slot counter and dout hold; frame_sync has no effect.
REQ-020 Latency: dout slice and matching dout_valid bit update at the same edge that accepts the sample (registered outputs; visible in the cycle after input presented).
REQ-021 dout_valid is one-hot or zero; each bit is high exactly one cycle per write.
REQ-022 frame_done is high in the same cycle as dout_valid[NUM_CH-1]; never otherwise.
REQ-023 Unwritten channels retain their previous value; no clearing at frame start.
REQ-024 err_count saturates at 255; no wrap.
REQ-025 Back-to-back din_valid every cycle is supported with no bubbles; a sync in the cycle after frame_done starts a new frame with no gap.
REQ-026 Outputs depend only on registered state; no combinational path din/din_valid/frame_sync to any output.

Reset
REQ-027 rst_n=0 immediately forces: state HUNT, slot 0, dout all zeros, dout_valid 0, frame_done 0, frame_err 0, err_count 0.
REQ-028 Reset mid-frame discards the partial frame; after release the block requires a new frame_sync before any write.
REQ-029 First accept possible on the first rising edge with rst_n=1.

Verification
REQ-030 Clean frame: after reset, din 0x11(sync),0x22,0x33,0x44 on consecutive cycles -> dout=0x44332211, dout_valid 0001,0010,0100,1000, frame_done with last, err_count 0.
REQ-031 Hunt: din 0xAA,0xBB without sync then 0x01(sync),0x02,0x03,0x04 -> 0xAA/0xBB dropped, dout=0x04030201, one frame_done.
REQ-032 Premature sync: 0x10(sync),0x20,0x30(sync),0x40,0x50,0x60 -> frame_err pulse with 0x30 write, err_count=1, final dout=0x60504030, one frame_done.
REQ-033 Gaps: clean frame with din_valid=0 for 3 cycles between each sample, frame_sync toggling during gaps -> same result as REQ-030, no extra strobes.
REQ-034 Reset mid-frame: 0x11(sync),0x22 then rst_n low 1 cycle, then 0x33,0x44 without sync -> dout=0, no dout_valid after reset.
REQ-035 Saturation: 300 consecutive premature syncs -> err_count holds 255, frame_err pulses continue.
